// File: rtl/decode.sv
// Decode stage: splits a 16-bit instruction into a registered operand bundle,
// owns the 8x16 register file and raises a load-use interlock.
// Optional feature: define DECODE_BYPASS_EN to forward same-cycle write-back
// data to operand reads (write-first). When undefined, reads return the old
// register value and a write becomes visible on the next cycle (read-first).
module decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic [15:0] pc,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        hold,
    output logic        d_valid,
    output logic [15:0] d_pc,
    output logic [3:0]  d_op,
    output logic [2:0]  d_rd,
    output logic [15:0] d_a,
    output logic [15:0] d_b,
    output logic [15:0] d_imm,
    output logic        d_wen,
    output logic        d_illegal
);

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpOr   = 4'd4;
    localparam logic [3:0] OpAddi = 4'd5;
    localparam logic [3:0] OpLd   = 4'd6;
    localparam logic [3:0] OpSt   = 4'd7;
    localparam logic [3:0] OpBeq  = 4'd8;
    localparam logic [3:0] OpJmp  = 4'd9;

    // Register file; entry 0 is never written so it always reads zero.
    logic [15:0] r_rf [8];

    // Output bundle registers
    logic        r_valid;
    logic [15:0] r_pc;
    logic [3:0]  r_op;
    logic [2:0]  r_rd;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_imm;
    logic        r_wen;
    logic        r_illegal;

    // Instruction fields
    logic [3:0]  w_op;
    logic [2:0]  w_f1;
    logic [2:0]  w_f2;
    logic [2:0]  w_f3;
    logic [15:0] w_sext6;
    logic [15:0] w_sext12;

    assign w_op     = inst[15:12];
    assign w_f1     = inst[11:9];
    assign w_f2     = inst[8:6];
    assign w_f3     = inst[5:3];
    assign w_sext6  = {{10{inst[5]}}, inst[5:0]};
    assign w_sext12 = {{4{inst[11]}}, inst[11:0]};

    // Decoded (pre-register) bundle
    logic        w_a_is_reg;
    logic        w_b_is_reg;
    logic [2:0]  w_src_b;
    logic [2:0]  w_dec_rd;
    logic [15:0] w_dec_imm;
    logic        w_dec_wen;
    logic        w_dec_ill;
    logic [15:0] w_val_a;
    logic [15:0] w_val_b;
    logic [15:0] w_dec_a;
    logic [15:0] w_dec_b;
    logic        w_hazard;

    // Field selection per opcode class
    always_comb begin
        w_a_is_reg = 1'b0;
        w_b_is_reg = 1'b0;
        w_src_b    = w_f3;
        w_dec_rd   = 3'd0;
        w_dec_imm  = 16'd0;
        w_dec_wen  = 1'b0;
        w_dec_ill  = 1'b0;
        case (w_op)
            OpAdd, OpSub, OpAnd, OpOr: begin
                w_dec_rd   = w_f1;
                w_a_is_reg = 1'b1;
                w_b_is_reg = 1'b1;
                w_src_b    = w_f3;
                w_dec_wen  = 1'b1;
            end
            OpAddi, OpLd: begin
                w_dec_rd   = w_f1;
                w_a_is_reg = 1'b1;
                w_dec_imm  = w_sext6;
                w_dec_wen  = 1'b1;
            end
            OpSt, OpBeq: begin
                w_a_is_reg = 1'b1;
                w_b_is_reg = 1'b1;
                w_src_b    = w_f1;
                w_dec_imm  = w_sext6;
            end
            OpJmp: begin
                w_dec_imm = w_sext12;
            end
            OpNop: begin
            end
            default: begin
                w_dec_ill = 1'b1;
            end
        endcase
        // A write to R0 would be discarded anyway; suppress it at the source.
        if (w_dec_rd == 3'd0) begin
            w_dec_wen = 1'b0;
        end
    end

    // Register file read ports
    always_comb begin
        w_val_a = (w_f2 == 3'd0) ? 16'd0 : r_rf[w_f2];
        w_val_b = (w_src_b == 3'd0) ? 16'd0 : r_rf[w_src_b];
`ifdef DECODE_BYPASS_EN
        if (wb_en && (wb_addr == w_f2) && (w_f2 != 3'd0)) begin
            w_val_a = wb_data;
        end
        if (wb_en && (wb_addr == w_src_b) && (w_src_b != 3'd0)) begin
            w_val_b = wb_data;
        end
`else
        // Read-first: a same-cycle write-back is seen by the next instruction.
`endif
    end

    assign w_dec_a = w_a_is_reg ? w_val_a : 16'd0;
    assign w_dec_b = w_b_is_reg ? w_val_b : 16'd0;

    // Load-use hazard: the load in the output register feeds a source here.
    assign w_hazard = r_valid && (r_op == OpLd) && (r_rd != 3'd0) && in_valid &&
                      ((w_a_is_reg && (w_f2 == r_rd)) || (w_b_is_reg && (w_src_b == r_rd)));

    // Fetch interlock; forced low while in reset.
    assign hold = !rst && !flush && (stall || w_hazard);

    // Register file write-back, independent of the pipeline controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                r_rf[k] <= 16'd0;
            end
        end else if (wb_en && (wb_addr != 3'd0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Output bundle: flush > stall > hazard bubble > accept > idle bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= 16'd0;
            r_op      <= 4'd0;
            r_rd      <= 3'd0;
            r_a       <= 16'd0;
            r_b       <= 16'd0;
            r_imm     <= 16'd0;
            r_wen     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_valid   <= 1'b1;
            r_pc      <= pc;
            r_op      <= w_op;
            r_rd      <= w_dec_rd;
            r_a       <= w_dec_a;
            r_b       <= w_dec_b;
            r_imm     <= w_dec_imm;
            r_wen     <= w_dec_wen;
            r_illegal <= w_dec_ill;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign d_valid   = r_valid;
    assign d_pc      = r_pc;
    assign d_op      = r_op;
    assign d_rd      = r_rd;
    assign d_a       = r_a;
    assign d_b       = r_b;
    assign d_imm     = r_imm;
    assign d_wen     = r_wen;
    assign d_illegal = r_illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed scenarios followed by random traffic, all checked
// against an instruction-level reference model of the decode stage.
module tb_decode;

    typedef struct packed {
        logic        v;
        logic [15:0] pc;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        wen;
        logic        ill;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst = 16'd0;
    logic [15:0] pc = 16'd0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = 3'd0;
    logic [15:0] wb_data = 16'd0;
    logic        hold;
    logic        d_valid;
    logic [15:0] d_pc;
    logic [3:0]  d_op;
    logic [2:0]  d_rd;
    logic [15:0] d_a;
    logic [15:0] d_b;
    logic [15:0] d_imm;
    logic        d_wen;
    logic        d_illegal;

    decode dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .pc        (pc),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .hold      (hold),
        .d_valid   (d_valid),
        .d_pc      (d_pc),
        .d_op      (d_op),
        .d_rd      (d_rd),
        .d_a       (d_a),
        .d_b       (d_b),
        .d_imm     (d_imm),
        .d_wen     (d_wen),
        .d_illegal (d_illegal)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_regs [8];
    bundle_t     m_out;
    logic        last_hold;

    function automatic bundle_t dut_bundle();
        return {d_valid, d_pc, d_op, d_rd, d_a, d_b, d_imm, d_wen, d_illegal};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural register read as the decode stage should see it this cycle.
    function automatic logic [15:0] reg_read(input logic [2:0] idx);
        if (idx == 3'd0) return 16'd0;
`ifdef DECODE_BYPASS_EN
        if (wb_en && wb_addr == idx) return wb_data;
`endif
        return m_regs[idx];
    endfunction

    function automatic bundle_t ref_decode(input logic [15:0] i, input logic [15:0] p);
        bundle_t     r;
        int          op;
        logic [15:0] s6;
        logic [15:0] s12;
        op  = int'(i[15:12]);
        s6  = {{10{i[5]}}, i[5:0]};
        s12 = {{4{i[11]}}, i[11:0]};
        r    = '0;
        r.v  = 1'b1;
        r.pc = p;
        r.op = i[15:12];
        if (op >= 1 && op <= 4) begin
            r.rd = i[11:9]; r.a = reg_read(i[8:6]); r.b = reg_read(i[5:3]); r.wen = 1'b1;
        end else if (op == 5 || op == 6) begin
            r.rd = i[11:9]; r.a = reg_read(i[8:6]); r.imm = s6; r.wen = 1'b1;
        end else if (op == 7 || op == 8) begin
            r.a = reg_read(i[8:6]); r.b = reg_read(i[11:9]); r.imm = s6;
        end else if (op == 9) begin
            r.imm = s12;
        end else if (op >= 10) begin
            r.ill = 1'b1;
        end
        if (r.rd == 3'd0) r.wen = 1'b0;
        return r;
    endfunction

    function automatic logic ref_hazard(input logic [15:0] i, input logic iv);
        int   op;
        logic use_a;
        logic use_b3;
        logic use_b1;
        op     = int'(i[15:12]);
        use_a  = (op >= 1 && op <= 8);
        use_b3 = (op >= 1 && op <= 4);
        use_b1 = (op == 7 || op == 8);
        return m_out.v && (m_out.op == 4'd6) && (m_out.rd != 3'd0) && iv &&
               ((use_a && i[8:6] == m_out.rd) || (use_b3 && i[5:3] == m_out.rd) ||
                (use_b1 && i[11:9] == m_out.rd));
    endfunction

    // One clock cycle: drive, check hold, advance the model, check the bundle.
    task automatic step(input logic [15:0] i, input logic [15:0] p, input logic iv,
                        input logic st, input logic fl, input logic we,
                        input logic [2:0] wa, input logic [15:0] wd);
        bundle_t nxt;
        logic    haz;
        inst = i; pc = p; in_valid = iv; stall = st; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        haz = ref_hazard(i, iv);
        last_hold = hold;
        chk("hold", hold, !fl && (st || haz));
        nxt = m_out;
        if (fl) nxt.v = 1'b0;
        else if (!st) begin
            if (haz) nxt.v = 1'b0;
            else if (iv) nxt = ref_decode(i, p);
            else nxt.v = 1'b0;
        end
        @(posedge clk);
        m_out = nxt;
        if (we && wa != 3'd0) m_regs[wa] = wd;
        #1;
        chk("bundle", dut_bundle(), m_out);
    endtask

    initial begin
        bundle_t zero_b;
        zero_b = '0;
        for (int k = 0; k < 8; k++) m_regs[k] = 16'd0;
        m_out = '0;
        last_hold = 1'b0;

        // Reset state
        #2;
        chk("rst_out", dut_bundle(), zero_b);
        chk("rst_hold", hold, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load R1=5, R2=3, then ADD R1,R2,R1
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd5);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'd3);
        step(16'h1288, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("add_valid", {d_valid, d_op, d_rd}, {1'b1, 4'd1, 3'd1});
        chk("add_ops", {d_a, d_b, d_wen}, {16'd3, 16'd5, 1'b1});

        // Immediates
        step(16'h527F, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("addi_imm", d_imm, 16'hFFFF);
        step(16'h9800, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("jmp_imm", {d_imm, d_wen}, {16'hF800, 1'b0});

        // Load-use: LD R3 then ADD R4,R3,R1
        step(16'h6640, 16'h0013, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("ld_op", {d_valid, d_op, d_rd}, {1'b1, 4'd6, 3'd3});
        step(16'h18C8, 16'h0014, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("haz_hold", last_hold, 1'b1);
        chk("haz_bubble", d_valid, 1'b0);
        step(16'h18C8, 16'h0014, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("haz_hold2", last_hold, 1'b0);
        chk("haz_emit", {d_valid, d_op, d_pc}, {1'b1, 4'd1, 16'h0014});

        // Same-cycle write-back to R2 while reading R2
        step(16'h1288, 16'h0015, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 16'h1234);
`ifdef DECODE_BYPASS_EN
        chk("bypass_a", d_a, 16'h1234);
`else
        chk("bypass_a", d_a, 16'd3);
`endif
        step(16'h1288, 16'h0016, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("wb_visible", d_a, 16'h1234);

        // Illegal opcode and R0 write
        step(16'hF000, 16'h0017, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'hBEEF);
        chk("illegal", {d_valid, d_op, d_illegal, d_wen}, {1'b1, 4'hF, 1'b1, 1'b0});
        step(16'h1200, 16'h0018, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("r0_reads_zero", {d_a, d_b}, 32'd0);

        // Stall three cycles, then flush during stall
        step(16'h527F, 16'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            step(16'h1288, 16'h0021, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
            chk("stall_hold", hold, 1'b1);
            chk("stall_keep", {d_valid, d_op, d_pc}, {1'b1, 4'd5, 16'h0020});
        end
        step(16'h1288, 16'h0021, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 16'd0);
        chk("flush_hold", last_hold, 1'b0);
        chk("flush_valid", d_valid, 1'b0);

        // Asynchronous reset in the middle of a stall
        step(16'h1288, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        step(16'h527F, 16'h0031, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out", dut_bundle(), zero_b);
        chk("rst_mid_hold", hold, 1'b0);
        m_out = '0;
        for (int k = 0; k < 8; k++) m_regs[k] = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        step(16'h1288, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
        chk("post_rst", {d_valid, d_pc, d_a, d_b}, {1'b1, 16'h0040, 16'd0, 16'd0});

        // Random traffic, biased toward loads so interlocks occur
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ri[15:12] = 4'd6;
            step(ri, 16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 Port rst, input, 1, reset, asynchronous, active-high.
REQ-003 Port inst, input, 16, instruction word from fetch stage.
REQ-004 Port pc, input, 16, address of inst.
REQ-005 Port in_valid, input, 1, inst/pc valid this cycle.
REQ-006 Port stall, input, 1, downstream cannot accept; hold output register.
REQ-007 Port flush, input, 1, discard current and in-flight instruction (taken branch).
REQ-008 Port wb_en, input, 1; wb_addr, input, 3; wb_data, input, 16: register write-back.
REQ-009 Port hold, output, 1, fetch SHALL NOT advance pc while high.
REQ-010 Ports d_valid 1, d_pc 16, d_op 4, d_rd 3, d_a 16, d_b 16, d_imm 16, d_wen 1, d_illegal 1, all outputs, registered decoded bundle.

Function
REQ-011 Fields: op=inst[15:12], f1=inst[11:9], f2=inst[8:6], f3=inst[5:3], imm6=inst[5:0], imm12=inst[11:0].
REQ-012 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LD, 7 ST, 8 BEQ, 9 JMP; 10-15 illegal.
REQ-013 R-type (1-4): rd=f1, a=R[f2], b=R[f3], wen=1, imm=0.
REQ-014 ADDI/LD: rd=f1, a=R[f2], b=0, imm=sext(imm6), wen=1.
REQ-015 ST/BEQ: a=R[f2], b=R[f1], imm=sext(imm6), rd=0, wen=0.
REQ-016 JMP: imm=sext(imm12), a=b=0, rd=0, wen=0; NOP: all fields 0, wen=0.
REQ-017 Illegal op: bundle as NOP with d_illegal=1, d_op=inst[15:12].
REQ-018 Register file 8x16; R0 reads 0 always, writes to R0 ignored; wen forced 0 when rd=0.
REQ-019 Write-back occurs on rising edge when wb_en=1, independent of stall/flush/hold.
REQ-020 Latency: one cycle; inst accepted at edge N appears on d_* after edge N.
REQ-021 Accept condition: in_valid && !stall && !flush && !hazard; on accept d_valid<=1, bundle loaded.
REQ-022 stall=1 and flush=0: all d_* retain value; hold=1.
REQ-023 flush=1: d_valid<=0 next edge regardless of stall/hazard; hold=0; flush has highest priority.
REQ-024 Hazard: d_valid=1, d_op=LD, d_rd!=0, current inst valid and reads d_rd as a or b source.
REQ-025 Hazard with stall=0: d_valid<=0 (bubble), hold=1 combinationally; same inst accepted next cycle.
REQ-026 in_valid=0 with no stall/flush: d_valid<=0, other d_* retain value.
REQ-027 hold = (stall && !flush) || (hazard && !flush), combinational.
REQ-028 Sign extension: bit 5 (imm6) or bit 11 (imm12) replicated to bit 15.

Reset
REQ-029 rst high: d_valid=0, all other d_* =0, all registers R0-R7 =0, immediately (asynchronous).
REQ-030 rst asserted mid-stall or mid-hazard: state cleared; first post-reset edge with in_valid accepts normally; hold=0 during reset.

Configuration
REQ-031 Macro DECODE_BYPASS_EN defined: wb_en to a register read in the same cycle forwards wb_data to d_a/d_b (write-first).
REQ-032 DECODE_BYPASS_EN undefined: same-cycle read returns old register value (read-first); write visible next cycle.

Verification
REQ-033 Reset then R1=5,R2=3 via wb; inst 0x1288 (ADD R1,R2,R1) valid -> next cycle d_valid=1,d_op=1,d_rd=1,d_a=3,d_b=5,d_wen=1.
REQ-034 inst 0x527F (ADDI R1,R1,-1) -> d_imm=0xFFFF; inst 0x9800 (JMP) -> d_imm=0xF800,d_wen=0.
REQ-035 LD R3 then ADD reading R3 -> hold=1 one cycle, one bubble (d_valid=0), ADD emitted following cycle.
REQ-036 stall=1 for 3 cycles with valid bundle -> d_* unchanged, hold=1; flush=1 during stall -> d_valid=0 next edge, hold=0.
REQ-037 wb_en=1,wb_addr=2,wb_data=0x1234 same cycle as read of R2 -> d_a=0x1234 with DECODE_BYPASS_EN, old value without.
REQ-038 inst 0xF000 -> d_illegal=1,d_wen=0; wb to R0 -> R0 still reads 0; rst mid-stall -> all outputs 0 immediately.
